// File: rtl/jaxa_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jaxa_pio_pkg
// Purpose  : Shared types for the PIO master: FSM states and queued command.
// Revision : 1.0 - initial release
// ============================================================================
package jaxa_pio_pkg;

    localparam int PIO_DATA_W     = 32;
    // Widest slave address a queued command can carry; ADDR_W must not exceed it.
    localparam int PIO_ADDR_MAX_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RBACK = 3'd3,
        ST_RESP  = 3'd4
    } pio_state_t;

    typedef struct packed {
        logic                      write;
        logic [PIO_ADDR_MAX_W-1:0] address;
        logic [PIO_DATA_W-1:0]     data;
    } pio_cmd_t;

endpackage
`default_nettype wire

// File: rtl/jaxa_pio_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : jaxa_pio_cmd_fifo
// Purpose  : Synchronous command queue, full/empty flags, registered storage.
// Revision : 1.0 - initial release
// ============================================================================
module jaxa_pio_cmd_fifo
    import jaxa_pio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_push,
    input  pio_cmd_t i_data,
    input  logic     i_pop,
    output pio_cmd_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int AW = $clog2(DEPTH);

    pio_cmd_t        r_mem [DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic            w_push;
    logic            w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/jaxa_pio_master.sv
`default_nettype none
// ============================================================================
// Module   : jaxa_pio_master
// Purpose  : Queued single-beat Avalon-MM initiator for SpaceWire PIO slaves.
//            Optional write readback: JAXA_PIO_MASTER_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module jaxa_pio_master
    import jaxa_pio_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_address,
    input  logic [PIO_DATA_W-1:0] cmd_writedata,
    output logic                  rsp_valid,
    output logic [PIO_DATA_W-1:0] rsp_readdata,
    output logic                  rsp_error,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic [PIO_DATA_W-1:0] avm_writedata,
    input  logic [PIO_DATA_W-1:0] avm_readdata,
    output logic                  busy
);

    localparam int              CNT_W      = 2;
    localparam logic [CNT_W-1:0] c_read_lat = CNT_W'(READ_LATENCY);

    pio_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    pio_cmd_t         w_cmd;
    pio_cmd_t         w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;

    assign w_cmd.write   = cmd_write;
    assign w_cmd.address = PIO_ADDR_MAX_W'(cmd_address);
    assign w_cmd.data    = cmd_writedata;

    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign cmd_ready = !w_full;
    assign busy      = !w_empty || (r_state != ST_IDLE);

    jaxa_pio_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cmd_valid),
        .i_data  (w_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= '0;
            avm_writedata  <= '0;
            rsp_valid      <= 1'b0;
            rsp_readdata   <= '0;
            rsp_error      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        avm_address    <= ADDR_W'(w_head.address);
                        avm_chipselect <= 1'b1;
                        r_cnt          <= c_read_lat;
                        if (w_head.write) begin
                            avm_writedata <= w_head.data;
                            avm_write_n   <= 1'b0;
                            r_state       <= ST_WRITE;
                        end else begin
                            avm_write_n   <= 1'b1;
                            r_state       <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    avm_write_n <= 1'b1;
`ifdef JAXA_PIO_MASTER_READBACK_EN
                    // Chipselect stays high: the readback read follows directly.
                    r_cnt       <= c_read_lat;
                    r_state     <= ST_RBACK;
`else
                    avm_chipselect <= 1'b0;
                    rsp_valid      <= 1'b1;
                    rsp_readdata   <= '0;
                    rsp_error      <= 1'b0;
                    r_state        <= ST_RESP;
`endif
                end
                ST_READ: begin
                    if (r_cnt == '0) begin
                        avm_chipselect <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_readdata   <= avm_readdata;
                        rsp_error      <= 1'b0;
                        r_state        <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef JAXA_PIO_MASTER_READBACK_EN
                ST_RBACK: begin
                    if (r_cnt == '0) begin
                        avm_chipselect <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_readdata   <= avm_readdata;
                        rsp_error      <= (avm_readdata != avm_writedata);
                        r_state        <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jaxa_pio_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_jaxa_pio_master
// Purpose  : Self-checking bench for jaxa_pio_master against a PIO slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jaxa_pio_master;

    localparam int L     = 2;
    localparam int DEPTH = 4;
    localparam int LOGN  = 4096;
`ifdef JAXA_PIO_MASTER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    // Cycles from bus start to the last bus cycle of a write command.
    localparam int WDUR = RB ? (L + 2) : 1;
    localparam int RDUR = L + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_address = 2'd0;
    logic [31:0] cmd_writedata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_readdata;
    logic        rsp_error;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    jaxa_pio_master #(
        .ADDR_W         (2),
        .FIFO_DEPTH     (DEPTH),
        .READ_LATENCY   (L)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_address    (cmd_address),
        .cmd_writedata  (cmd_writedata),
        .rsp_valid      (rsp_valid),
        .rsp_readdata   (rsp_readdata),
        .rsp_error      (rsp_error),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: address 0 is an autoStart-style one-bit register, others full width.
    logic [31:0] sreg [4];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) sreg[i] <= 32'd0;
        end else if (avm_chipselect && !avm_write_n) begin
            sreg[avm_address] <= (avm_address == 2'd0) ? {31'd0, avm_writedata[0]} : avm_writedata;
        end
    end
    assign avm_readdata = sreg[avm_address];

    logic        cs_log [LOGN];
    logic        wn_log [LOGN];
    logic        rv_log [LOGN];
    logic        er_log [LOGN];
    logic        op_log [LOGN];
    logic [1:0]  ad_log [LOGN];
    logic [31:0] wd_log [LOGN];
    logic [31:0] rd_log [LOGN];
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            cs_log[cyc] <= avm_chipselect;
            wn_log[cyc] <= avm_write_n;
            rv_log[cyc] <= rsp_valid;
            er_log[cyc] <= rsp_error;
            op_log[cyc] <= sreg[0][0];
            ad_log[cyc] <= avm_address;
            wd_log[cyc] <= avm_writedata;
            rd_log[cyc] <= rsp_readdata;
        end
    end

    // Presents one command (called #1 after a rising edge); returns acceptance cycle.
    task automatic push_one(input bit w, input logic [1:0] a, input logic [31:0] d,
                            input bit keep, output int t_acc);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_writedata = d;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        t_acc = cyc;
        @(posedge clk); #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", cmd_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rv: got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_readdata !== 32'd0) $display("FAIL rst_rd: got %h want 0", rsp_readdata); else n_pass++;
        n_checks++; if (rsp_error !== 1'b0) $display("FAIL rst_err: got %b want 0", rsp_error); else n_pass++;
        n_checks++; if (avm_chipselect !== 1'b0) $display("FAIL rst_cs: got %b want 0", avm_chipselect); else n_pass++;
        n_checks++; if (avm_write_n !== 1'b1) $display("FAIL rst_wn: got %b want 1", avm_write_n); else n_pass++;
        n_checks++; if (avm_address !== 2'd0) $display("FAIL rst_addr: got %h want 0", avm_address); else n_pass++;
        n_checks++; if (avm_writedata !== 32'd0) $display("FAIL rst_wd: got %h want 0", avm_writedata); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        int t;
        push_one(1'b1, 2'd0, 32'h1, 1'b0, t);
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (cs_log[t+1] !== 1'b0) $display("FAIL wr_cs_pre: got %b want 0", cs_log[t+1]); else n_pass++;
        n_checks++; if (cs_log[t+2] !== 1'b1) $display("FAIL wr_cs: got %b want 1", cs_log[t+2]); else n_pass++;
        n_checks++; if (wn_log[t+2] !== 1'b0) $display("FAIL wr_wn: got %b want 0", wn_log[t+2]); else n_pass++;
        n_checks++; if (wd_log[t+2] !== 32'h1) $display("FAIL wr_wd: got %h want 1", wd_log[t+2]); else n_pass++;
        n_checks++; if (wn_log[t+3] !== 1'b1) $display("FAIL wr_wn_post: got %b want 1", wn_log[t+3]); else n_pass++;
        n_checks++; if (cs_log[t+3] !== RB) $display("FAIL wr_cs_post: got %b want %b", cs_log[t+3], RB); else n_pass++;
        n_checks++; if (op_log[t+2] !== 1'b0) $display("FAIL wr_port_pre: got %b want 0", op_log[t+2]); else n_pass++;
        n_checks++; if (op_log[t+3] !== 1'b1) $display("FAIL wr_port: got %b want 1", op_log[t+3]); else n_pass++;
        n_checks++; if (rv_log[t+1+WDUR] !== 1'b0) $display("FAIL wr_rv_early: got %b want 0", rv_log[t+1+WDUR]); else n_pass++;
        n_checks++; if (rv_log[t+2+WDUR] !== 1'b1) $display("FAIL wr_rv: got %b want 1", rv_log[t+2+WDUR]); else n_pass++;
        n_checks++; if (rv_log[t+3+WDUR] !== 1'b0) $display("FAIL wr_rv_len: got %b want 0", rv_log[t+3+WDUR]); else n_pass++;
        n_checks++; if (rd_log[t+2+WDUR] !== 32'(RB)) $display("FAIL wr_rd: got %h want %h", rd_log[t+2+WDUR], 32'(RB)); else n_pass++;
    endtask

    task automatic test_read();
        int t;
        push_one(1'b0, 2'd0, 32'hDEAD_BEEF, 1'b0, t);
        repeat (8) @(posedge clk);
        #1;
        for (int k = 2; k <= 2 + L; k++) begin
            n_checks++; if (cs_log[t+k] !== 1'b1) $display("FAIL rd_cs[%0d]: got %b want 1", k, cs_log[t+k]); else n_pass++;
            n_checks++; if (wn_log[t+k] !== 1'b1) $display("FAIL rd_wn[%0d]: got %b want 1", k, wn_log[t+k]); else n_pass++;
        end
        n_checks++; if (cs_log[t+3+L] !== 1'b0) $display("FAIL rd_cs_end: got %b want 0", cs_log[t+3+L]); else n_pass++;
        n_checks++; if (rv_log[t+2+L] !== 1'b0) $display("FAIL rd_rv_early: got %b want 0", rv_log[t+2+L]); else n_pass++;
        n_checks++; if (rv_log[t+3+L] !== 1'b1) $display("FAIL rd_rv: got %b want 1", rv_log[t+3+L]); else n_pass++;
        n_checks++; if (rd_log[t+3+L] !== 32'h1) $display("FAIL rd_data: got %h want 1", rd_log[t+3+L]); else n_pass++;
        n_checks++; if (er_log[t+3+L] !== 1'b0) $display("FAIL rd_err: got %b want 0", er_log[t+3+L]); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rd_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc [5];
        int pop [5];
        logic [1:0]  ad [5];
        logic [31:0] wd [5];
        int npulse = 0;
        for (int i = 0; i < 5; i++) begin
            ad[i] = 2'($urandom_range(1, 3));
            wd[i] = $urandom;
            push_one(1'b1, ad[i], wd[i], i < 4, acc[i]);
        end
        for (int i = 0; i < 5; i++) begin
            pop[i] = acc[i] + 1;
            if (i > 0 && pop[i-1] + WDUR + 2 > pop[i]) pop[i] = pop[i-1] + WDUR + 2;
        end
        while (cyc < pop[4] + WDUR + 4) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (cs_log[pop[i]] !== 1'b0) $display("FAIL b2b_gap[%0d]: got %b want 0", i, cs_log[pop[i]]); else n_pass++;
            n_checks++; if (cs_log[pop[i]+1] !== 1'b1 || wn_log[pop[i]+1] !== 1'b0)
                $display("FAIL b2b_wr[%0d]: got cs=%b wn=%b want cs=1 wn=0", i, cs_log[pop[i]+1], wn_log[pop[i]+1]); else n_pass++;
            n_checks++; if (ad_log[pop[i]+1] !== ad[i] || wd_log[pop[i]+1] !== wd[i])
                $display("FAIL b2b_bus[%0d]: got %h/%h want %h/%h", i, ad_log[pop[i]+1], wd_log[pop[i]+1], ad[i], wd[i]); else n_pass++;
            n_checks++; if (rv_log[pop[i]+1+WDUR] !== 1'b1) $display("FAIL b2b_rv[%0d]: got %b want 1", i, rv_log[pop[i]+1+WDUR]); else n_pass++;
        end
        for (int c = acc[0]; c < pop[4] + WDUR + 4; c++) if (rv_log[c] === 1'b1) npulse++;
        n_checks++; if (npulse != 5) $display("FAIL b2b_pulses: got %0d want 5", npulse); else n_pass++;
    endtask

    task automatic test_queue_full();
        int acc [6];
        int npulse = 0;
        for (int i = 0; i < 6; i++) begin
            push_one(1'b0, 2'($urandom_range(0, 3)), 32'd0, i < 5, acc[i]);
        end
        for (int i = 1; i < 5; i++) begin
            n_checks++; if (acc[i] != acc[0] + i) $display("FAIL full_acc[%0d]: got %0d want %0d", i, acc[i] - acc[0], i); else n_pass++;
        end
        // Queue fills at the fifth push; the next slot opens after the second pop.
        n_checks++; if (acc[5] != acc[0] + 7) $display("FAIL full_stall: got %0d want 7", acc[5] - acc[0]); else n_pass++;
        repeat (36) @(posedge clk);
        #1;
        for (int c = acc[0]; c < acc[0] + 36; c++) if (rv_log[c] === 1'b1) npulse++;
        n_checks++; if (npulse != 6) $display("FAIL full_pulses: got %0d want 6", npulse); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL full_busy_end: got %b want 0", busy); else n_pass++;
    endtask

`ifdef JAXA_PIO_MASTER_READBACK_EN
    task automatic test_readback();
        int t;
        push_one(1'b1, 2'd0, 32'h3, 1'b0, t);
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (cs_log[t+3] !== 1'b1 || wn_log[t+3] !== 1'b1)
            $display("FAIL rb_read: got cs=%b wn=%b want 1/1", cs_log[t+3], wn_log[t+3]); else n_pass++;
        n_checks++; if (rv_log[t+4+L] !== 1'b1) $display("FAIL rb_rv: got %b want 1", rv_log[t+4+L]); else n_pass++;
        n_checks++; if (rd_log[t+4+L] !== 32'h1) $display("FAIL rb_rd: got %h want 1", rd_log[t+4+L]); else n_pass++;
        n_checks++; if (er_log[t+4+L] !== 1'b1) $display("FAIL rb_err: got %b want 1", er_log[t+4+L]); else n_pass++;
        push_one(1'b1, 2'd0, 32'h1, 1'b0, t);
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (rd_log[t+4+L] !== 32'h1) $display("FAIL rb_rd_ok: got %h want 1", rd_log[t+4+L]); else n_pass++;
        n_checks++; if (er_log[t+4+L] !== 1'b0) $display("FAIL rb_err_ok: got %b want 0", er_log[t+4+L]); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_read();
        int t;
        int r0;
        int nrv = 0;
        int ncs = 0;
        push_one(1'b0, 2'd1, 32'd0, 1'b0, t);
        @(posedge clk); #2;
        n_checks++; if (avm_chipselect !== 1'b1) $display("FAIL mid_cs_before: got %b want 1", avm_chipselect); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (avm_chipselect !== 1'b0) $display("FAIL mid_cs_async: got %b want 0", avm_chipselect); else n_pass++;
        n_checks++; if (avm_write_n !== 1'b1) $display("FAIL mid_wn: got %b want 1", avm_write_n); else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        r0 = cyc;
        repeat (10) @(posedge clk);
        #1;
        for (int c = r0; c < r0 + 10; c++) begin
            if (rv_log[c] === 1'b1) nrv++;
            if (cs_log[c] === 1'b1) ncs++;
        end
        n_checks++; if (nrv != 0) $display("FAIL mid_no_rsp: got %0d pulses want 0", nrv); else n_pass++;
        n_checks++; if (ncs != 0) $display("FAIL mid_no_bus: got %0d cs cycles want 0", ncs); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", cmd_ready); else n_pass++;
    endtask

    // Reference: commands complete in order against a word-addressed register
    // file; pops happen once the FSM has been idle after the previous response.
    task automatic test_random();
        localparam int N = 40;
        int acc_a [N];
        int pop_a [N];
        int rsp_a [N];
        logic [31:0] erd [N];
        bit          eer [N];
        logic [31:0] mem [4];
        int nacc = 0;
        int occ;
        int prev_end = 0;
        int budget = 0;
        int npulse = 0;
        bit pend = 1'b0;
        bit pw;
        logic [1:0] pa;
        logic [31:0] pd, st;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) mem[i] = 32'd0;
        while (nacc < N && budget < 3000) begin
            if (!pend && $urandom_range(0, 9) < 6) begin
                pend = 1'b1;
                pw = 1'($urandom_range(0, 1));
                pa = 2'($urandom_range(0, 3));
                pd = $urandom;
            end
            cmd_valid = pend; cmd_write = pw; cmd_address = pa; cmd_writedata = pd;
            occ = nacc;
            for (int j = 0; j < nacc; j++) if (pop_a[j] < cyc) occ--;
            n_checks++; if (cmd_ready !== (occ < DEPTH)) $display("FAIL rnd_ready@%0d: got %b want %b", cyc, cmd_ready, occ < DEPTH); else n_pass++;
            if (pend && occ < DEPTH) begin
                acc_a[nacc] = cyc;
                pop_a[nacc] = (cyc + 1 > prev_end) ? cyc + 1 : prev_end;
                if (pw) begin
                    st = (pa == 2'd0) ? (pd & 32'h1) : pd;
                    mem[pa] = st;
                    erd[nacc] = RB ? st : 32'd0;
                    eer[nacc] = RB && (st != pd);
                    rsp_a[nacc] = pop_a[nacc] + 1 + WDUR;
                end else begin
                    erd[nacc] = mem[pa];
                    eer[nacc] = 1'b0;
                    rsp_a[nacc] = pop_a[nacc] + 1 + RDUR;
                end
                prev_end = rsp_a[nacc] + 1;
                nacc++;
                pend = 1'b0;
            end
            @(posedge clk); #1;
            budget++;
        end
        cmd_valid = 1'b0;
        n_checks++; if (nacc != N) $display("FAIL rnd_budget: got %0d accepted want %0d", nacc, N); else n_pass++;
        if (nacc == N) begin
            while (cyc < rsp_a[N-1] + 3) @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                n_checks++; if (rv_log[rsp_a[k]] !== 1'b1 || rd_log[rsp_a[k]] !== erd[k] || er_log[rsp_a[k]] !== eer[k])
                    $display("FAIL rnd_rsp[%0d]: got v=%b d=%h e=%b want v=1 d=%h e=%b", k,
                             rv_log[rsp_a[k]], rd_log[rsp_a[k]], er_log[rsp_a[k]], erd[k], eer[k]); else n_pass++;
            end
            for (int c = acc_a[0]; c < rsp_a[N-1] + 3; c++) if (rv_log[c] === 1'b1) npulse++;
            n_checks++; if (npulse != N) $display("FAIL rnd_pulses: got %0d want %0d", npulse, N); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_queue_full();
`ifdef JAXA_PIO_MASTER_READBACK_EN
        test_readback();
`endif
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
